imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered, parametrised immediate-decode pipeline stage sitting between fetch and the register-read/execute boundary of the 5-stage core. It accepts one instruction and its PC per handshake and classifies the immediate format. It emits the sign- or zero-extended immediate and flags malformed encodings. It also precomputes the PC-relative target for branch, jump and AUIPC, and buffers through downstream stalls with a two-entry skid buffer.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- EN_ZICSR, 1: when 1, CSR immediate forms (zimm) are decoded; when 0, SYSTEM opcode yields fmt NONE.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill from branch resolution.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; a beat transfers on in_valid && in_ready.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded result available.
- out_ready  in  1  downstream accepts; a beat transfers on out_valid && out_ready.
- out_instr  out  32  instruction passthrough.
- out_pc  out  XLEN  PC passthrough.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  imm_fmt_e code.
- out_target  out  XLEN  out_pc + out_imm for fmt B, J and AUIPC; otherwise 0.
- out_illegal  out  1  encoding cannot be decoded.

## Operation
- Opcode classification:
  - I: 0010011, 0000011, 1100111, plus 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Z: 1110011 with funct3[2]=1 and EN_ZICSR=1.
  - NONE: 0110011, 0111011 (XLEN=64 only), 0001111, and 1110011 otherwise.
- Immediate values:
  - I, S, B, U and J immediates are sign-extended from instr[31] to XLEN.
  - U is {instr[31:12], 12'b0}, sign-extended to XLEN.
  - Z is the zero-extended instr[19:15].
  - NONE yields 0.
- Shift format SH: OP-IMM with funct3 001 or 101. The immediate is the zero-extended shamt: instr[24:20] for XLEN=32 and for 0011011; instr[25:20] for XLEN=64 on 0010011.
- out_illegal is set when any of the following holds; when set, out_imm=0, out_target=0 and out_fmt=NONE:
  - instr[1:0] != 11;
  - the opcode is unlisted;
  - XLEN=32 and an SH instruction has instr[25]=1;
  - an SH instruction has funct7/funct6 other than 0 or 0100000/010000.
- out_target is computed with XLEN-bit wrap-around; carry is discarded.
- Buffering:
  - Main register plus one skid register.
  - If the main register is stalled (out_valid && !out_ready) while in_ready is high, the incoming beat goes to skid.
  - When main drains, skid moves into main.
  - in_ready = !skid_valid, driven from a register.
- flush clears both valid bits on the next edge. A beat presented in the flush cycle is discarded. Data registers are not cleared.
- Illegal instructions still travel down the pipe; out_illegal is the only marker.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on out_* after edge N.
- Throughput is 1 beat/cycle while out_ready=1.
- Reset values:
  - out_valid=0, in_ready=1, out_illegal=0.
  - out_imm, out_target, out_pc and out_instr all 0.
  - out_fmt=NONE.
  - skid empty.
- Simultaneous events:
  - Simultaneous drain and fill keeps occupancy constant.
  - With both entries full and out_ready=1, main takes skid and in_ready rises the next cycle.
- out_* stay stable while out_valid && !out_ready.
- Reset asserted mid-stream empties both entries immediately (asynchronous).

## Structure
- imm_pkg holds:
  - typedef enum logic [2:0] imm_fmt_e {NONE, I, S, B, U, J, Z, SH};
  - opcode localparams;
  - the pure function decode_imm(instr) returning fmt, imm and illegal.
- Sub-module imm_extract: combinational, XLEN-parametrised, instantiated once on the input side. Only the result is registered. The adder for out_target sits before the register, so out_target is registered.
- The top level holds the handshake, the skid buffer and flush.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) -> out_imm=0xFFFFFFFF, fmt I, illegal 0, 1 cycle later.
- 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, fmt S; 0x123452B7 (lui x5) -> 0x12345000, fmt U.
- 0xFE000CE3 (beq -8) with pc=0x100 -> out_imm=0xFFFFFFF8, out_target=0x000000F8; with pc=0x4 -> target 0xFFFFFFFC (wrap).
- XLEN=32, 0x02009093 (slli shamt 32) -> out_illegal=1, out_imm=0; same word at XLEN=64 -> fmt SH, imm=0x20.
- Hold out_ready=0 while streaming 3 instructions -> in_ready falls after 2 accepted, out_* stable. Release -> beats emerge in order, none lost or duplicated.
- Assert flush with both entries full and in_valid=1 -> out_valid=0 and in_ready=1 the next cycle, with no beat emitted.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: shared types, opcode constants and the pure immediate decoder for
// the immediate-decode stage.
//   imm_fmt_e    - immediate format code carried on out_fmt
//   buf_state_e  - occupancy of the main/skid buffer pair (debug visible)
//   imm_dec_t    - decoder result: format, 64-bit immediate, illegal flag
//   decode_imm() - classifies an instruction word and builds its immediate;
//                  the immediate is always produced at 64 bits and callers
//                  truncate to XLEN (sign extension survives truncation).
package imm_pkg;

    typedef enum logic [2:0] {NONE, I, S, B, U, J, Z, SH} imm_fmt_e;

    typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_e;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

    typedef struct packed {
        imm_fmt_e    fmt;
        logic [63:0] imm;
        logic        illegal;
    } imm_dec_t;

    function automatic imm_dec_t decode_imm(input logic [31:0] instr,
                                            input logic        rv64,
                                            input logic        en_zicsr);
        imm_dec_t   d;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       is_shift;
        logic       f7_ok;
        logic       f6_ok;

        d.fmt     = NONE;
        d.imm     = '0;
        d.illegal = 1'b0;
        opc       = instr[6:0];
        f3        = instr[14:12];
        is_shift  = (f3 == 3'b001) || (f3 == 3'b101);
        // Shift encodings only allow the logical (all zero) or arithmetic
        // (bit 30 set) upper field.
        f7_ok     = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000);
        f6_ok     = (instr[31:26] == 6'b000000)  || (instr[31:26] == 6'b010000);

        if (instr[1:0] != 2'b11) begin
            d.illegal = 1'b1;
        end else begin
            case (opc)
                OPC_OP_IMM: begin
                    if (is_shift) begin
                        d.fmt = SH;
                        if (rv64) begin
                            d.imm     = {58'b0, instr[25:20]};
                            d.illegal = !f6_ok;
                        end else begin
                            d.imm     = {59'b0, instr[24:20]};
                            d.illegal = instr[25] || !f7_ok;
                        end
                    end else begin
                        d.fmt = I;
                        d.imm = {{52{instr[31]}}, instr[31:20]};
                    end
                end
                OPC_OP_IMM_32: begin
                    if (!rv64) begin
                        d.illegal = 1'b1;
                    end else if (is_shift) begin
                        d.fmt     = SH;
                        d.imm     = {59'b0, instr[24:20]};
                        d.illegal = !f7_ok;
                    end else begin
                        d.fmt = I;
                        d.imm = {{52{instr[31]}}, instr[31:20]};
                    end
                end
                OPC_LOAD, OPC_JALR: begin
                    d.fmt = I;
                    d.imm = {{52{instr[31]}}, instr[31:20]};
                end
                OPC_STORE: begin
                    d.fmt = S;
                    d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OPC_BRANCH: begin
                    d.fmt = B;
                    d.imm = {{51{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    d.fmt = U;
                    d.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
                end
                OPC_JAL: begin
                    d.fmt = J;
                    d.imm = {{43{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    if (f3[2] && en_zicsr) begin
                        d.fmt = Z;
                        d.imm = {59'b0, instr[19:15]};
                    end
                end
                OPC_OP, OPC_MISC_MEM: begin
                    d.fmt = NONE;
                end
                OPC_OP_32: begin
                    d.illegal = !rv64;
                end
                default: begin
                    d.illegal = 1'b1;
                end
            endcase
        end

        // An undecodable word carries no immediate information downstream.
        if (d.illegal) begin
            d.fmt = NONE;
            d.imm = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if: upstream and downstream handshake bundle of the
// immediate-decode stage.
// Handshake rule (both sides): a beat transfers on the rising clock edge where
// valid && ready are both high; the sender holds its payload stable while
// valid is high and ready is low, and ready never depends on valid.
//   in_*   : fetch -> stage (in_valid, in_instr, in_pc) and in_ready back
//   out_*  : stage -> execute (out_valid and decoded payload), out_ready back
// Modports: master = the side driving instructions in / consuming results
//           slave  = the decode stage itself
interface imm_decode_stage_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    imm_fmt_e        out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt,
               out_target, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt,
               out_target, out_illegal
    );
endinterface

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate extraction for one instruction.
//   instr/pc   in  : raw instruction and its address
//   fmt        out : immediate format
//   imm        out : immediate truncated to XLEN
//   target     out : pc + imm for B, J and AUIPC, else 0 (wraps at XLEN)
//   illegal    out : encoding cannot be decoded
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] target,
    output logic            illegal
);
    imm_dec_t dec;
    logic     pc_rel;

    assign dec     = decode_imm(instr, XLEN == 64, EN_ZICSR);
    assign fmt     = dec.fmt;
    assign imm     = dec.imm[XLEN-1:0];
    assign illegal = dec.illegal;

    // LUI and AUIPC share fmt U; only AUIPC is PC-relative.
    assign pc_rel  = (dec.fmt == B) || (dec.fmt == J) ||
                     ((dec.fmt == U) && (instr[6:0] == OPC_AUIPC));
    assign target  = pc_rel ? (pc + imm) : '0;

    generate
        if (XLEN < 64) begin : g_narrow
            // Upper immediate bits are pure sign copies on a narrow core.
            logic unused_hi;
            assign unused_hi = |dec.imm[63:XLEN];
        end
    endgenerate
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate-decode stage with a two-entry
// (main + skid) buffer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous kill of both entries; a beat offered in the
//                 flush cycle is dropped
//   bus         : slave side of imm_decode_stage_if (in_* / out_* handshake)
//   dbg_state   : buffer occupancy for observation
// Decoding happens before the register so out_target is a registered value.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit EN_ZICSR = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_decode_stage_if.slave   bus,
    output buf_state_e          dbg_state
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        imm_fmt_e        fmt;
        logic            illegal;
    } beat_t;

    beat_t      dec_beat;
    beat_t      main_q;
    beat_t      skid_q;
    buf_state_e state;
    buf_state_e state_nxt;
    logic       out_valid_q;
    logic       in_ready_q;
    logic       accept;
    logic       drain;
    logic       load_main_in;
    logic       load_main_skid;
    logic       load_skid;

    imm_extract #(
        .XLEN     (XLEN),
        .EN_ZICSR (EN_ZICSR)
    ) u_extract (
        .instr   (bus.in_instr),
        .pc      (bus.in_pc),
        .fmt     (dec_beat.fmt),
        .imm     (dec_beat.imm),
        .target  (dec_beat.target),
        .illegal (dec_beat.illegal)
    );
    assign dec_beat.instr = bus.in_instr;
    assign dec_beat.pc    = bus.in_pc;

    assign accept = bus.in_valid && in_ready_q && !flush;
    assign drain  = out_valid_q && bus.out_ready;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = BUF_EMPTY;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_nxt    = BUF_ONE;
                        load_main_in = 1'b1;
                    end
                end
                BUF_ONE: begin
                    case ({drain, accept})
                        2'b11: load_main_in = 1'b1;
                        2'b10: state_nxt    = BUF_EMPTY;
                        2'b01: begin
                            // Main is stalled, so the new beat parks in skid.
                            state_nxt = BUF_FULL;
                            load_skid = 1'b1;
                        end
                        default: ;
                    endcase
                end
                BUF_FULL: begin
                    if (drain) begin
                        state_nxt      = BUF_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = BUF_EMPTY;
            endcase
        end
    end

    // Handshake outputs come straight from flops, not from a state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BUF_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt != BUF_EMPTY);
            in_ready_q  <= (state_nxt != BUF_FULL);
        end
    end

    // Data registers are not touched by flush; only the valid state is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_skid) begin
                skid_q <= dec_beat;
            end
            if (load_main_in) begin
                main_q <= dec_beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_instr   = main_q.instr;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_fmt     = main_q.fmt;
    assign bus.out_target  = main_q.target;
    assign bus.out_illegal = main_q.illegal;
    assign dbg_state       = state;
endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;
  import imm_pkg::*;

  localparam int W32 = 132;
  localparam int W64 = 228;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) bus32();
  imm_decode_stage_if #(.XLEN(64)) bus64();
  buf_state_e dbg32;
  buf_state_e dbg64;

  imm_decode_stage #(.XLEN(32), .EN_ZICSR(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus32), .dbg_state(dbg32)
  );
  imm_decode_stage #(.XLEN(64), .EN_ZICSR(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64), .dbg_state(dbg64)
  );

  // ---------------- scoreboard ----------------
  logic [W32-1:0] exp_q[$];
  logic [W64-1:0] exp64_q[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send32(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] tgt,
                        input imm_fmt_e fmt, input logic ill);
    bit done = 1'b0;
    bus32.in_valid = 1'b1;
    bus32.in_instr = instr;
    bus32.in_pc = pc;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = bus32.in_ready;
      @(posedge clk);
      #1;
    end
    if (done) exp_q.push_back({instr, pc, imm, tgt, fmt, ill});
    else check("accept_timeout32", {255'b0, bus32.in_ready}, 256'd1);
    bus32.in_valid = 1'b0;
  endtask

  task automatic send64(input logic [31:0] instr, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [63:0] tgt,
                        input imm_fmt_e fmt, input logic ill);
    bit done = 1'b0;
    bus64.in_valid = 1'b1;
    bus64.in_instr = instr;
    bus64.in_pc = pc;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = bus64.in_ready;
      @(posedge clk);
      #1;
    end
    if (done) exp64_q.push_back({instr, pc, imm, tgt, fmt, ill});
    else check("accept_timeout64", {255'b0, bus64.in_ready}, 256'd1);
    bus64.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  logic [W32-1:0] snap32;
  logic stalled32 = 1'b0;

  always @(negedge clk) begin
    logic [W32-1:0] act;
    if (rst_n) begin
      act = {bus32.out_instr, bus32.out_pc, bus32.out_imm, bus32.out_target,
             bus32.out_fmt, bus32.out_illegal};
      if (stalled32 && bus32.out_valid) check("stable32", act, snap32);
      if (bus32.out_valid && bus32.out_ready) begin
        if (exp_q.size() == 0) check("unexpected32", {255'b0, bus32.out_valid}, 256'd0);
        else check("beat32", act, exp_q.pop_front());
      end
      stalled32 = bus32.out_valid && !bus32.out_ready;
      snap32 = act;
    end else begin
      stalled32 = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [W64-1:0] act;
    if (rst_n && bus64.out_valid && bus64.out_ready) begin
      act = {bus64.out_instr, bus64.out_pc, bus64.out_imm, bus64.out_target,
             bus64.out_fmt, bus64.out_illegal};
      if (exp64_q.size() == 0) check("unexpected64", {255'b0, bus64.out_valid}, 256'd0);
      else check("beat64", act, exp64_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    bus32.in_valid = 1'b0; bus32.in_instr = '0; bus32.in_pc = '0; bus32.out_ready = 1'b1;
    bus64.in_valid = 1'b0; bus64.in_instr = '0; bus64.in_pc = '0; bus64.out_ready = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", {255'b0, bus32.out_valid}, 256'd0);
    check("rst_in_ready", {255'b0, bus32.in_ready}, 256'd1);
    check("rst_illegal", {255'b0, bus32.out_illegal}, 256'd0);
    check("rst_imm", {224'b0, bus32.out_imm}, 256'd0);
    check("rst_target", {224'b0, bus32.out_target}, 256'd0);
    check("rst_pc", {224'b0, bus32.out_pc}, 256'd0);
    check("rst_instr", {224'b0, bus32.out_instr}, 256'd0);
    check("rst_fmt", {253'b0, bus32.out_fmt}, {253'b0, NONE});
    check("rst_skid_empty", {254'b0, dbg32}, {254'b0, BUF_EMPTY});
    rst_n = 1'b1;
    cycles(1);

    // XLEN=32 directed vectors, back to back
    send32(32'hFFF00093, 32'h0, 32'hFFFFFFFF, 32'h0, I, 1'b0);
    check("latency_valid", {255'b0, bus32.out_valid}, 256'd1);
    check("latency_imm", {224'b0, bus32.out_imm}, {224'b0, 32'hFFFFFFFF});
    send32(32'hFE112E23, 32'h0, 32'hFFFFFFFC, 32'h0, S, 1'b0);
    send32(32'h123452B7, 32'h0, 32'h12345000, 32'h0, U, 1'b0);
    send32(32'hFE000CE3, 32'h100, 32'hFFFFFFF8, 32'h000000F8, B, 1'b0);
    send32(32'hFE000CE3, 32'h4, 32'hFFFFFFF8, 32'hFFFFFFFC, B, 1'b0);
    send32(32'h02009093, 32'h0, 32'h0, 32'h0, NONE, 1'b1);
    send32(32'h00001117, 32'h200, 32'h00001000, 32'h00001200, U, 1'b0);
    send32(32'h008000EF, 32'h40, 32'h8, 32'h48, J, 1'b0);
    send32(32'h3002D073, 32'h0, 32'h5, 32'h0, Z, 1'b0);
    send32(32'h002081B3, 32'h0, 32'h0, 32'h0, NONE, 1'b0);
    send32(32'h00000001, 32'h0, 32'h0, 32'h0, NONE, 1'b1);
    send32(32'h0000000B, 32'h0, 32'h0, 32'h0, NONE, 1'b1);
    send32(32'h4030D093, 32'h0, 32'h3, 32'h0, SH, 1'b0);
    send32(32'h2030D093, 32'h0, 32'h0, 32'h0, NONE, 1'b1);
    send32(32'h0000003B, 32'h0, 32'h0, 32'h0, NONE, 1'b1);
    send32(32'h80002083, 32'h0, 32'hFFFFF800, 32'h0, I, 1'b0);

    // XLEN=64 (EN_ZICSR=0) directed vectors
    send64(32'h02009093, 64'h0, 64'h20, 64'h0, SH, 1'b0);
    send64(32'hFFF00093, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, I, 1'b0);
    send64(32'h0010009B, 64'h0, 64'h1, 64'h0, I, 1'b0);
    send64(32'h0200909B, 64'h0, 64'h0, 64'h0, NONE, 1'b1);
    send64(32'h0000003B, 64'h0, 64'h0, 64'h0, NONE, 1'b0);
    send64(32'hFE000CE3, 64'h4, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC, B, 1'b0);
    send64(32'h3002D073, 64'h0, 64'h0, 64'h0, NONE, 1'b0);
    send64(32'h4030D093, 64'h0, 64'h3, 64'h0, SH, 1'b0);
    cycles(3);

    // stall: two accepted, third held off, outputs stable
    bus32.out_ready = 1'b0;
    send32(32'h00100093, 32'h10, 32'h1, 32'h0, I, 1'b0);
    send32(32'h00200113, 32'h14, 32'h2, 32'h0, I, 1'b0);
    bus32.in_valid = 1'b1;
    bus32.in_instr = 32'h00300193;
    bus32.in_pc = 32'h18;
    @(negedge clk);
    check("stall_in_ready", {255'b0, bus32.in_ready}, 256'd0);
    check("stall_full", {254'b0, dbg32}, {254'b0, BUF_FULL});
    check("stall_out_valid", {255'b0, bus32.out_valid}, 256'd1);
    repeat (3) @(negedge clk);
    check("stall_hold_ready", {255'b0, bus32.in_ready}, 256'd0);
    @(posedge clk);
    #1;
    bus32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_rise", {255'b0, bus32.in_ready}, 256'd1);
    send32(32'h00300193, 32'h18, 32'h3, 32'h0, I, 1'b0);
    cycles(4);
    check("stall_drained", {224'b0, 32'(exp_q.size())}, 256'd0);

    // flush with both entries full and a beat offered
    bus32.out_ready = 1'b0;
    send32(32'h00400213, 32'h20, 32'h4, 32'h0, I, 1'b0);
    send32(32'h00500293, 32'h24, 32'h5, 32'h0, I, 1'b0);
    @(negedge clk);
    check("pre_flush_full", {255'b0, bus32.in_ready}, 256'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    bus32.in_valid = 1'b1;
    bus32.in_instr = 32'h00600313;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus32.in_valid = 1'b0;
    check("flush_out_valid", {255'b0, bus32.out_valid}, 256'd0);
    check("flush_in_ready", {255'b0, bus32.in_ready}, 256'd1);
    exp_q.delete();
    bus32.out_ready = 1'b1;
    // flush while empty: the offered beat is dropped
    flush = 1'b1;
    bus32.in_valid = 1'b1;
    bus32.in_instr = 32'h00700393;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus32.in_valid = 1'b0;
    check("flush_drop", {255'b0, bus32.out_valid}, 256'd0);
    cycles(4);

    // asynchronous reset mid-stream
    bus32.out_ready = 1'b0;
    send32(32'h00800413, 32'h30, 32'h8, 32'h0, I, 1'b0);
    send32(32'h00900493, 32'h34, 32'h9, 32'h0, I, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", {255'b0, bus32.out_valid}, 256'd0);
    check("areset_in_ready", {255'b0, bus32.in_ready}, 256'd1);
    check("areset_imm", {224'b0, bus32.out_imm}, 256'd0);
    exp_q.delete();
    exp64_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus32.out_ready = 1'b1;
    cycles(1);
    send32(32'hFFF00093, 32'h0, 32'hFFFFFFFF, 32'h0, I, 1'b0);

    for (int k = 0; k < 20 && (exp_q.size() != 0 || exp64_q.size() != 0); k++) cycles(1);
    check("final_drain32", {224'b0, 32'(exp_q.size())}, 256'd0);
    check("final_drain64", {224'b0, 32'(exp64_q.size())}, 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
